serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: i_CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_VALID  input  1  operands present on i_A/i_B/i_CIN.
REQ-005 SHALL have port: o_READY  output  1  block can accept an operand pair.
REQ-006 SHALL have port: i_A  input  WIDTH  operand A.
REQ-007 SHALL have port: i_B  input  WIDTH  operand B.
REQ-008 SHALL have port: i_CIN  input  1  carry-in.
REQ-009 SHALL have port: o_BIT_VALID  output  1  high while o_SUM_BIT carries a sum bit.
REQ-010 SHALL have port: o_SUM_BIT  output  1  serial sum bit, LSB first.
REQ-011 SHALL have port: o_SUM  output  WIDTH  parallel sum result.
REQ-012 SHALL have port: o_COUT  output  1  final carry-out.
REQ-013 SHALL have port: o_DONE  output  1  one-cycle result-valid pulse.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-015 SHALL drive o_READY high only in IDLE.
REQ-016 SHALL accept a transaction on the rising edge where i_VALID and o_READY are both high, then enter RUN.
REQ-017 SHALL, on acceptance, load A and B shift registers, set the carry register to i_CIN, and clear the bit counter and sum register.
REQ-018 SHALL ignore i_VALID, i_A, i_B and i_CIN outside IDLE, so operand changes during RUN do not affect the result.
REQ-019 SHALL, in each RUN cycle, compute bit = a0 XOR b0 XOR c and carry = majority(a0, b0, c) from two half adders and an OR gate.
REQ-020 SHALL present that cycle's bit on o_SUM_BIT with o_BIT_VALID high.
REQ-021 SHALL, at the end of each RUN cycle, shift the bit into the MSB of the sum register (right shift), shift A and B right by one, register the carry, and increment the counter.
REQ-022 SHALL remain in RUN for exactly WIDTH cycles, moving to DONE after the counter reaches WIDTH-1.
REQ-023 SHALL, in DONE, assert o_DONE for exactly one cycle with o_SUM = (A+B+CIN) mod 2^WIDTH and o_COUT = bit WIDTH of that sum, then return to IDLE.
REQ-024 SHALL hold o_SUM and o_COUT stable from DONE until the next accepted transaction.
REQ-025 SHALL give an accept-edge to o_DONE-high latency of WIDTH+1 cycles and a minimum accept-to-accept interval of WIDTH+2 cycles.
REQ-026 SHALL hold o_SUM_BIT at 0 whenever o_BIT_VALID is low.
REQ-027 SHALL leave o_SUM and o_COUT undefined in value, but with no X/glitch requirement, while in RUN.

Reset
REQ-028 SHALL, when i_RST_N is low, immediately force state IDLE, all shift, carry and counter registers to 0, and o_SUM=0, o_COUT=0, o_DONE=0, o_BIT_VALID=0, o_SUM_BIT=0 and o_READY=1, regardless of clock.
REQ-029 SHALL, on reset assertion mid-RUN or in DONE, abort the transaction with no o_DONE pulse and no partial result retained.
REQ-030 SHALL make the first accept possible on the first rising edge after i_RST_N deasserts.

Verification
REQ-031 SHALL cover: WIDTH=8, A=0x00, B=0x00, CIN=0 -> o_DONE 9 cycles after accept, o_SUM=0x00, o_COUT=0, all serial bits 0.
REQ-032 SHALL cover: A=0xFF, B=0x01, CIN=0 -> o_SUM=0x00, o_COUT=1, serial stream 0,0,0,0,0,0,0,0.
REQ-033 SHALL cover: A=0x5A, B=0xA5, CIN=1 -> o_SUM=0x00, o_COUT=1; and A=0x0F, B=0x01, CIN=0 -> o_SUM=0x10, o_COUT=0, serial stream 0,0,0,0,1,0,0,0.
REQ-034 SHALL cover: i_VALID held high with operands changed every cycle during RUN -> result matches operands at accept edge, and the next accept occurs exactly 10 cycles after the first.
REQ-035 SHALL cover: i_RST_N pulsed low during the 4th RUN cycle -> outputs at reset values immediately, no o_DONE, o_READY=1 and next transaction correct.
REQ-036 SHALL cover: a random self-checking loop of at least 1000 transactions, compared against A+B+CIN, with each serial bit checked against the matching result bit.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, WIDTH run cycles per operand pair
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_CIN,
  output logic             o_BIT_VALID,
  output logic             o_SUM_BIT,
  output logic [WIDTH-1:0] o_SUM,
  output logic             o_COUT,
  output logic             o_DONE
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

  // full adder built from two half adders and an OR for the carry
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    ha2_s = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (i_VALID) begin
          state_d = S_RUN;
          a_d     = i_A;
          b_d     = i_B;
          c_d     = i_CIN;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        sum_d = {ha2_s, sum_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  // sum and carry registers double as the held result once the run completes
  assign o_READY     = (state_q == S_IDLE);
  assign o_BIT_VALID = (state_q == S_RUN);
  assign o_SUM_BIT   = o_BIT_VALID & ha2_s;
  assign o_DONE      = (state_q == S_DONE);
  assign o_SUM       = sum_q;
  assign o_COUT      = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_a = 8'h00;
  logic [7:0] i_b = 8'h00;
  logic       i_cin = 1'b0;
  logic       o_bit_valid;
  logic       o_sum_bit;
  logic [7:0] o_sum;
  logic       o_cout;
  logic       o_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = -100;

  serial_adder #(.WIDTH(8)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(i_valid), .o_READY(o_ready),
    .i_A(i_a), .i_B(i_b), .i_CIN(i_cin),
    .o_BIT_VALID(o_bit_valid), .o_SUM_BIT(o_sum_bit),
    .o_SUM(o_sum), .o_COUT(o_cout), .o_DONE(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after DONE.
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [8:0] exp9, input bit scramble, input bit chain);
    chk1("ready_idle", o_ready, 1'b1);
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_cin = cin;
    @(negedge clk);
    if (chain) chk1("accept_interval", (cyc - last_acc) == 10, 1'b1);
    last_acc = cyc;
    for (int k = 0; k < 8; k++) begin
      chk1("bit_valid", o_bit_valid, 1'b1);
      chk1("sum_bit", o_sum_bit, exp9[k]);
      chk1("ready_run", o_ready, 1'b0);
      chk1("done_run", o_done, 1'b0);
      if (scramble) begin
        i_valid = 1'b1;
        i_a = 8'($urandom);
        i_b = 8'($urandom);
        i_cin = 1'($urandom);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk1("done_pulse", o_done, 1'b1);
    chk8("sum", o_sum, exp9[7:0]);
    chk1("cout", o_cout, exp9[8]);
    chk1("bit_valid_done", o_bit_valid, 1'b0);
    chk1("sum_bit_done", o_sum_bit, 1'b0);
    @(negedge clk);
    chk1("done_one_cycle", o_done, 1'b0);
    chk8("sum_hold", o_sum, exp9[7:0]);
    chk1("cout_hold", o_cout, exp9[8]);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] re;
    bit         rs;

    #1;
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_bit_valid", o_bit_valid, 1'b0);
    chk1("rst_sum_bit", o_sum_bit, 1'b0);
    chk8("rst_sum", o_sum, 8'h00);
    chk1("rst_cout", o_cout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    txn(8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
    txn(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0);
    txn(8'h5A, 8'hA5, 1'b1, 9'h100, 1'b0, 1'b0);
    txn(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0, 1'b0);
    txn(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, 1'b0);
    txn(8'h80, 8'h80, 1'b0, 9'h100, 1'b0, 1'b0);
    txn(8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b0);
    txn(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0, 1'b0);

    // operands churn during RUN with valid held high; back-to-back accepts
    txn(8'h3C, 8'h47, 1'b1, 9'h084, 1'b1, 1'b0);
    txn(8'hC8, 8'h64, 1'b0, 9'h12C, 1'b1, 1'b1);
    i_valid = 1'b0;
    @(negedge clk);

    // reset in the 4th RUN cycle
    i_valid = 1'b1;
    i_a = 8'hC3;
    i_b = 8'h3C;
    i_cin = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_ready", o_ready, 1'b1);
    chk1("midrst_bit_valid", o_bit_valid, 1'b0);
    chk1("midrst_sum_bit", o_sum_bit, 1'b0);
    chk8("midrst_sum", o_sum, 8'h00);
    chk1("midrst_cout", o_cout, 1'b0);
    chk1("midrst_done", o_done, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1("midrst_no_done", o_done, 1'b0);
      if (k == 2) rst_n = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(8'h7E, 8'h81, 1'b1, 9'h100, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      re = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      txn(ra, rb, rc, re, rs, 1'b0);
    end
    i_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
